seq_compare_unit: RTL and testbench

//  Multi-cycle magnitude/equality comparator for the ECPU math group; produces eq/lt/gt flags.

---
 rtl/ecpu_math_pkg.sv | 30 +++
 rtl/cmp_chunk.sv | 24 ++
 rtl/seq_compare_unit.sv | 164 ++++++++++++++++
 tb/tb_seq_compare_unit.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ecpu_math_pkg.sv
`default_nettype none
// ============================================================================
// Package     : ecpu_math_pkg
// Description : Shared types and sizing helpers for the ECPU math group
//               sequential comparator.
//               - cmp_state_t : comparator FSM states (IDLE, SCAN, DONE)
//               - calc_nchunk : number of CHUNK-wide slices in an operand
//               - calc_idx_w  : width of the slice index (minimum 1 bit)
// Revision    : 1.0 - initial release
// ============================================================================
package ecpu_math_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } cmp_state_t;

  function automatic int calc_nchunk(input int bus_size, input int chunk);
    return bus_size / chunk;
  endfunction

  // A single-chunk operand still needs a 1-bit index so the counter and
  // mux select never collapse to zero width.
  function automatic int calc_idx_w(input int nchunk);
    return (nchunk <= 1) ? 1 : $clog2(nchunk);
  endfunction

endpackage : ecpu_math_pkg
`default_nettype wire

// File: rtl/cmp_chunk.sv
`default_nettype none
// ============================================================================
// Module      : cmp_chunk
// Description : Combinational unsigned compare of one CHUNK-wide slice.
// Ports       : x     in  CHUNK  left slice
//               y     in  CHUNK  right slice
//               ch_eq out 1      x == y
//               ch_lt out 1      x <  y (unsigned)
// Revision    : 1.0 - initial release
// ============================================================================
module cmp_chunk #(
  parameter int CHUNK = 8
) (
  input  logic [CHUNK-1:0] x,
  input  logic [CHUNK-1:0] y,
  output logic             ch_eq,
  output logic             ch_lt
);

  assign ch_eq = (x == y);
  assign ch_lt = (x <  y);

endmodule : cmp_chunk
`default_nettype wire

// File: rtl/seq_compare_unit.sv
`default_nettype none
// ============================================================================
// Module      : seq_compare_unit
// Description : Multi-cycle magnitude/equality comparator. Operands are
//               scanned MSB-first, CHUNK bits per cycle, stopping at the
//               first differing chunk. Valid/ready on request and result.
// Ports       : clk          in   1         rising-edge clock
//               rst_n        in   1         async active-low reset
//               start_valid  in   1         request strobe
//               start_ready  out  1         unit idle, request accepted
//               a, b         in   BUS_SIZE  operands
//               is_signed    in   1         1 = two's-complement compare
//               res_valid    out  1         flags valid
//               res_ready    in   1         consumer accepts result
//               eq, lt, gt   out  1         comparison flags
// Revision    : 1.0 - initial release
// ============================================================================
module seq_compare_unit
  import ecpu_math_pkg::*;
#(
  parameter int BUS_SIZE = 32,
  parameter int CHUNK    = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start_valid,
  output logic                start_ready,
  input  logic [BUS_SIZE-1:0] a,
  input  logic [BUS_SIZE-1:0] b,
  input  logic                is_signed,
  output logic                res_valid,
  input  logic                res_ready,
  output logic                eq,
  output logic                lt,
  output logic                gt
);

  localparam int NCHUNK = calc_nchunk(BUS_SIZE, CHUNK);
  localparam int IDX_W  = calc_idx_w(NCHUNK);

  // Flipping the sign bit of both operands maps two's-complement order onto
  // unsigned order, so the scan itself is always an unsigned compare.
  localparam logic [BUS_SIZE-1:0] c_SIGN_MASK = BUS_SIZE'(1) << (BUS_SIZE - 1);
  localparam logic [IDX_W-1:0]    c_IDX_TOP   = IDX_W'(NCHUNK - 1);

  cmp_state_t          r_state;
  cmp_state_t          w_state_next;
  logic [BUS_SIZE-1:0] r_a;
  logic [BUS_SIZE-1:0] r_b;
  logic [IDX_W-1:0]    r_idx;
  logic                r_eq;
  logic                r_lt;
  logic                r_gt;

  logic [CHUNK-1:0]    w_a_ch [NCHUNK];
  logic [CHUNK-1:0]    w_b_ch [NCHUNK];
  logic [CHUNK-1:0]    w_x;
  logic [CHUNK-1:0]    w_y;
  logic                w_ch_eq;
  logic                w_ch_lt;
  logic                w_accept;
  logic                w_last;

  // Slice the latched operands into chunk arrays for the idx-selected mux.
  for (genvar gi = 0; gi < NCHUNK; gi++) begin : g_slices
    assign w_a_ch[gi] = r_a[gi*CHUNK +: CHUNK];
    assign w_b_ch[gi] = r_b[gi*CHUNK +: CHUNK];
  end

  assign w_x = w_a_ch[r_idx];
  assign w_y = w_b_ch[r_idx];

  cmp_chunk #(
    .CHUNK (CHUNK)
  ) u_cmp_chunk (
    .x     (w_x),
    .y     (w_y),
    .ch_eq (w_ch_eq),
    .ch_lt (w_ch_lt)
  );

  assign w_accept = (r_state == IDLE) && start_valid;
  assign w_last   = (r_idx == '0);

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next state and handshake outputs
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_next = r_state;
    start_ready  = 1'b0;
    res_valid    = 1'b0;
    case (r_state)
      IDLE: begin
        start_ready = 1'b1;
        if (start_valid) begin
          w_state_next = SCAN;
        end
      end
      SCAN: begin
        if (!w_ch_eq || w_last) begin
          w_state_next = DONE;
        end
      end
      DONE: begin
        res_valid = 1'b1;
        if (res_ready) begin
          w_state_next = IDLE;
        end
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Datapath: operand latches, index down-counter, result flags
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a   <= '0;
      r_b   <= '0;
      r_idx <= '0;
      r_eq  <= 1'b0;
      r_lt  <= 1'b0;
      r_gt  <= 1'b0;
    end else begin
      if (w_accept) begin
        r_a   <= is_signed ? (a ^ c_SIGN_MASK) : a;
        r_b   <= is_signed ? (b ^ c_SIGN_MASK) : b;
        r_idx <= c_IDX_TOP;
      end else if (r_state == SCAN) begin
        if (!w_ch_eq) begin
          r_eq <= 1'b0;
          r_lt <= w_ch_lt;
          r_gt <= ~w_ch_lt;
        end else if (w_last) begin
          r_eq <= 1'b1;
          r_lt <= 1'b0;
          r_gt <= 1'b0;
        end else begin
          r_idx <= r_idx - 1'b1;
        end
      end
    end
  end

  assign eq = r_eq;
  assign lt = r_lt;
  assign gt = r_gt;

endmodule : seq_compare_unit
`default_nettype wire

// File: tb/tb_seq_compare_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_seq_compare_unit
// Description : Scoreboard bench for seq_compare_unit. A driver issues
//               directed and random requests and pushes the expected flags
//               and completion cycle; a monitor pops and compares whenever
//               a new result appears, and checks hold/handshake behaviour.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seq_compare_unit;

  localparam int BUS   = 32;
  localparam int CH    = 8;
  localparam int NCH   = BUS / CH;

  typedef struct {
    logic eq;
    logic lt;
    logic gt;
    int   due;
  } exp_t;

  logic           clk;
  logic           rst_n;
  logic           start_valid;
  logic           start_ready;
  logic [BUS-1:0] a;
  logic [BUS-1:0] b;
  logic           is_signed;
  logic           res_valid;
  logic           res_ready;
  logic           eq;
  logic           lt;
  logic           gt;

  exp_t sb[$];
  int   checks;
  int   errors;
  int   cyc;
  int   rr_mode;   // 0: always ready, 1: random, 2: never ready
  int   idle_cnt;
  logic prev_v;
  logic prev_r;
  logic [2:0] held;

  seq_compare_unit #(
    .BUS_SIZE (BUS),
    .CHUNK    (CH)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start_valid (start_valid),
    .start_ready (start_ready),
    .a           (a),
    .b           (b),
    .is_signed   (is_signed),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .eq          (eq),
    .lt          (lt),
    .gt          (gt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  // Consumer readiness changes just after each rising edge.
  initial begin
    res_ready = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      case (rr_mode)
        0:       res_ready = 1'b1;
        1:       res_ready = 1'($urandom_range(0, 1));
        default: res_ready = 1'b0;
      endcase
    end
  end

  task automatic check(input bit ok, input string name, input logic [63:0] act, input logic [63:0] req);
    checks = checks + 1;
    if (!ok) begin
      errors = errors + 1;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference: compare as integers; latency is the MSB-first position of the
  // first differing chunk, or the full scan length for equal operands.
  function automatic exp_t model(input logic [BUS-1:0] x, input logic [BUS-1:0] y, input logic s, input int t_acc);
    exp_t e;
    int   k;
    e.eq = (x == y);
    e.lt = s ? ($signed(x) < $signed(y)) : (x < y);
    e.gt = !e.eq && !e.lt;
    k = NCH;
    for (int i = 1; i <= NCH; i++) begin
      if (x[BUS - CH*i +: CH] != y[BUS - CH*i +: CH]) begin
        k = i;
        break;
      end
    end
    e.due = t_acc + k;
    return e;
  endfunction

  // Called at a falling edge; returns at a falling edge after acceptance.
  task automatic issue(input logic [BUS-1:0] x, input logic [BUS-1:0] y, input logic s);
    bit done;
    done = 0;
    start_valid = 1'b1;
    a = x;
    b = y;
    is_signed = s;
    for (int n = 0; n < 200 && !done; n++) begin
      if (start_ready) begin
        sb.push_back(model(x, y, s, cyc + 1));
        @(posedge clk);
        #1;
        start_valid = 1'b0;
        a = $urandom;
        b = $urandom;
        is_signed = 1'($urandom_range(0, 1));
        done = 1;
      end
      @(negedge clk);
    end
    if (!done) begin
      check(1'b0, "accept_timeout", 64'(start_ready), 64'd1);
      start_valid = 1'b0;
    end
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 0;
    for (int n = 0; n < 300 && !ok; n++) begin
      @(negedge clk);
      if (sb.size() == 0 && start_ready && !res_valid) ok = 1;
    end
    if (!ok) check(1'b0, "idle_timeout", 64'(sb.size()), 64'd0);
  endtask

  // Monitor: sample away from the rising edge.
  initial begin
    prev_v   = 1'b0;
    prev_r   = 1'b0;
    held     = 3'b000;
    idle_cnt = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_v = 1'b0;
        prev_r = 1'b0;
        idle_cnt = 0;
      end else begin
        if (prev_v && prev_r) begin
          check(!res_valid, "drop_after_handshake", 64'(res_valid), 64'd0);
          check(start_ready, "idle_after_handshake", 64'(start_ready), 64'd1);
        end
        if (res_valid) begin
          check(!start_ready, "busy_start_ready", 64'(start_ready), 64'd0);
          check((32'(eq) + 32'(lt) + 32'(gt)) == 1, "onehot", 64'({eq, lt, gt}), 64'd1);
          if (!prev_v) begin
            if (sb.size() == 0) begin
              check(1'b0, "unexpected_result", 64'({eq, lt, gt}), 64'd0);
            end else begin
              exp_t e;
              e = sb.pop_front();
              check({eq, lt, gt} == {e.eq, e.lt, e.gt}, "flags", 64'({eq, lt, gt}), 64'({e.eq, e.lt, e.gt}));
              check(cyc == e.due, "latency", 64'(cyc), 64'(e.due));
            end
            idle_cnt = 0;
          end else begin
            check({eq, lt, gt} == held, "flags_stable", 64'({eq, lt, gt}), 64'(held));
          end
          held = {eq, lt, gt};
        end
        if (sb.size() > 0 && !res_valid) begin
          idle_cnt = idle_cnt + 1;
          if (idle_cnt > 40) begin
            check(1'b0, "result_timeout", 64'(sb.size()), 64'd0);
            sb.delete();
            idle_cnt = 0;
          end
        end else if (sb.size() == 0) begin
          idle_cnt = 0;
        end
        prev_v = res_valid;
        prev_r = res_ready;
      end
    end
  end

  initial begin
    checks      = 0;
    errors      = 0;
    rr_mode     = 0;
    rst_n       = 1'b0;
    start_valid = 1'b0;
    a           = '0;
    b           = '0;
    is_signed   = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    check(start_ready == 1'b1, "rst_start_ready", 64'(start_ready), 64'd1);
    check(res_valid == 1'b0, "rst_res_valid", 64'(res_valid), 64'd0);
    check({eq, lt, gt} == 3'b000, "rst_flags", 64'({eq, lt, gt}), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed cases
    issue(32'hDEADBEEF, 32'hDEADBEEF, 1'b0);
    issue(32'h01000000, 32'h00FFFFFF, 1'b0);
    issue(32'hFFFFFFFF, 32'h00000001, 1'b1);
    issue(32'hFFFFFFFF, 32'h00000001, 1'b0);
    issue(32'h12345678, 32'h12345679, 1'b0);
    issue(32'h80000000, 32'h7FFFFFFF, 1'b1);
    issue(32'h7FFFFFFF, 32'h80000000, 1'b0);
    wait_idle();

    // Backpressure: result must be held with the unit busy
    rr_mode = 2;
    @(negedge clk);
    issue(32'hCAFE0000, 32'hCAFE0001, 1'b1);
    begin
      bit seen;
      seen = 0;
      for (int n = 0; n < 20 && !seen; n++) begin
        if (res_valid) seen = 1;
        else @(negedge clk);
      end
      check(seen, "bp_result_seen", 64'(res_valid), 64'd1);
    end
    for (int n = 0; n < 5; n++) begin
      @(negedge clk);
      check(res_valid == 1'b1, "bp_hold_valid", 64'(res_valid), 64'd1);
      check(start_ready == 1'b0, "bp_hold_busy", 64'(start_ready), 64'd0);
    end
    rr_mode = 0;
    wait_idle();

    // Reset in the second SCAN cycle of an equal compare
    start_valid = 1'b1;
    a = 32'h5A5A5A5A;
    b = 32'h5A5A5A5A;
    is_signed = 1'b0;
    @(posedge clk);
    #1;
    start_valid = 1'b0;
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check(res_valid == 1'b0, "abort_res_valid", 64'(res_valid), 64'd0);
    check(start_ready == 1'b1, "abort_start_ready", 64'(start_ready), 64'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    issue(32'h00000010, 32'h00000020, 1'b0);
    wait_idle();

    // Randomized traffic with random consumer backpressure
    rr_mode = 1;
    for (int n = 0; n < 150; n++) begin
      logic [BUS-1:0] x;
      logic [BUS-1:0] y;
      int             sel;
      x   = $urandom;
      sel = $urandom_range(0, 2);
      case (sel)
        0:       y = $urandom;
        1:       y = x;
        default: y = x ^ (BUS'(1) << $urandom_range(0, BUS - 1));
      endcase
      issue(x, y, 1'($urandom_range(0, 1)));
    end
    rr_mode = 0;
    wait_idle();
    repeat (3) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_seq_compare_unit
`default_nettype wire
